// File: rtl/vernier_tdc_mc.sv
// ---------------------------------------------------------------------------
// vernier_tdc_mc : multi-channel Vernier time-to-digital converter.
//
// One shared start event and CHANNELS independent stop events. Each interval
// is a coarse clock-cycle count plus a fine correction. The fine correction
// is taken from delay-line thermometer codes captured at the start and stop
// edges:
//   result = coarse * 2^FINE_BITS + popcount(start_fine) - popcount(stop_fine)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-low
//   start       start event pulse (accepted only in IDLE)
//   start_fine  start thermometer code, TAPS wide
//   stop        per-channel stop pulses
//   stop_fine   per-channel stop thermometer codes, channel i at [i*TAPS +: TAPS]
//   result      per-channel interval, channel i at [i*W +: W]
//   valid       channel result captured
//   ovf         channel timed out without a stop (result forced all-ones)
//   busy        measurement running
//   done        one-cycle pulse when a measurement completes
// ---------------------------------------------------------------------------

// Ones count of a thermometer code. Counting ones instead of locating the
// transition makes the decode tolerant of bubbles.
module vernier_tdc_popcnt #(
    parameter int FINE_BITS = 3,
    parameter int TAPS      = (1 << FINE_BITS) - 1
) (
    input  logic [TAPS-1:0]      therm,
    output logic [FINE_BITS-1:0] bin
);
    always_comb begin
        bin = '0;
        for (int i = 0; i < TAPS; i++)
            bin = bin + FINE_BITS'(therm[i]);
    end
endmodule

// Per-channel datapath: fine decode, candidate interval and capture enable.
module vernier_tdc_lane #(
    parameter int COARSE_BITS = 6,
    parameter int FINE_BITS   = 3,
    parameter int TAPS        = (1 << FINE_BITS) - 1,
    parameter int W           = COARSE_BITS + FINE_BITS
) (
    input  logic                   run,
    input  logic                   stop,
    input  logic [TAPS-1:0]        stop_fine,
    input  logic                   valid_q,
    input  logic [COARSE_BITS-1:0] cnt,
    input  logic [FINE_BITS-1:0]   start_bin,
    output logic                   cap,
    output logic [W-1:0]           meas
);
    logic [FINE_BITS-1:0] stop_bin;

    vernier_tdc_popcnt #(.FINE_BITS(FINE_BITS), .TAPS(TAPS)) u_pc (
        .therm (stop_fine),
        .bin   (stop_bin)
    );

    // {cnt, start_bin} is cnt*2^FINE_BITS + start_bin; with cnt >= 1 and
    // stop_bin <= TAPS the difference is always >= 1, so no underflow.
    assign meas = {cnt, start_bin} - W'(stop_bin);
    assign cap  = run && stop && !valid_q;
endmodule

module vernier_tdc_mc #(
    parameter int CHANNELS    = 4,
    parameter int COARSE_BITS = 6,
    parameter int FINE_BITS   = 3,
    parameter int TAPS        = (1 << FINE_BITS) - 1,
    parameter int W           = COARSE_BITS + FINE_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [TAPS-1:0]          start_fine,
    input  logic [CHANNELS-1:0]      stop,
    input  logic [CHANNELS*TAPS-1:0] stop_fine,
    output logic [CHANNELS*W-1:0]    result,
    output logic [CHANNELS-1:0]      valid,
    output logic [CHANNELS-1:0]      ovf,
    output logic                     busy,
    output logic                     done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [COARSE_BITS-1:0] CNT_MAX = {COARSE_BITS{1'b1}};

    state_t                        state_q, state_d;
    logic [COARSE_BITS-1:0]        cnt_q, cnt_d;
    logic [FINE_BITS-1:0]          start_bin_q, start_bin_d;
    logic [CHANNELS-1:0][W-1:0]    result_q, result_d;
    logic [CHANNELS-1:0]           valid_q, valid_d;
    logic [CHANNELS-1:0]           ovf_q, ovf_d;

    logic [FINE_BITS-1:0]          start_pc;
    logic [CHANNELS-1:0]           cap;
    logic [CHANNELS-1:0][W-1:0]    meas;

    vernier_tdc_popcnt #(.FINE_BITS(FINE_BITS), .TAPS(TAPS)) u_start_pc (
        .therm (start_fine),
        .bin   (start_pc)
    );

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        vernier_tdc_lane #(
            .COARSE_BITS (COARSE_BITS),
            .FINE_BITS   (FINE_BITS),
            .TAPS        (TAPS),
            .W           (W)
        ) u_lane (
            .run       (state_q == RUN),
            .stop      (stop[g]),
            .stop_fine (stop_fine[g*TAPS +: TAPS]),
            .valid_q   (valid_q[g]),
            .cnt       (cnt_q),
            .start_bin (start_bin_q),
            .cap       (cap[g]),
            .meas      (meas[g])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_bin_d = start_bin_q;
        result_d    = result_q;
        valid_d     = valid_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    cnt_d       = COARSE_BITS'(1);
                    start_bin_d = start_pc;
                    result_d    = '0;
                    valid_d     = '0;
                    ovf_d       = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                for (int i = 0; i < CHANNELS; i++) begin
                    if (cap[i]) begin
                        result_d[i] = meas[i];
                        valid_d[i]  = 1'b1;
                    end
                end
                if (&valid_d) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_MAX) begin
                    // Last representable coarse count: time out the rest.
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (!valid_d[i]) begin
                            ovf_d[i]    = 1'b1;
                            result_d[i] = '1;
                        end
                    end
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            start_bin_q <= '0;
            result_q    <= '0;
            valid_q     <= '0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_bin_q <= start_bin_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign result = result_q;
    assign valid  = valid_q;
    assign ovf    = ovf_q;
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
endmodule

// File: tb/tb_vernier_tdc_mc.sv
// ---------------------------------------------------------------------------
// tb_vernier_tdc_mc : directed bench for vernier_tdc_mc with CHANNELS=2,
// COARSE_BITS=4, FINE_BITS=3 (TAPS=7, W=7). Edges are stepped one at a time;
// outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_vernier_tdc_mc;
    localparam int CH = 2, CB = 4, FB = 3, TAPS = 7, W = 7;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [TAPS-1:0]      start_fine;
    logic [CH-1:0]        stop;
    logic [CH*TAPS-1:0]   stop_fine;
    logic [CH*W-1:0]      result;
    logic [CH-1:0]        valid;
    logic [CH-1:0]        ovf;
    logic                 busy;
    logic                 done;

    int n_cmp = 0;
    int n_err = 0;

    vernier_tdc_mc #(.CHANNELS(CH), .COARSE_BITS(CB), .FINE_BITS(FB)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_fine (start_fine),
        .stop       (stop),
        .stop_fine  (stop_fine),
        .result     (result),
        .valid      (valid),
        .ovf        (ovf),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [W-1:0] res(input int i);
        return result[i*W +: W];
    endfunction

    initial begin
        reset = 1'b0; start = 1'b0; start_fine = '0; stop = '0; stop_fine = '0;
        step(2);
        chk("rst_result", 32'(result), 0);
        chk("rst_valid",  32'(valid),  0);
        chk("rst_ovf",    32'(ovf),    0);
        chk("rst_busy",   32'(busy),   0);
        chk("rst_done",   32'(done),   0);
        reset = 1'b1;
        step(1);

        // 1: basic measurement, 5*8+3-1=42 and 6*8+3-5=46
        start = 1'b1; start_fine = 7'b0000111;
        step(1);                            // E0
        start = 1'b0;
        chk("t1_busy", 32'(busy), 1);
        chk("t1_valid0", 32'(valid), 0);
        step(4);                            // E1..E4
        stop = 2'b01; stop_fine[6:0] = 7'b0000001;
        step(1);                            // E5
        stop = '0;
        chk("t1_res0",   32'(res(0)), 42);
        chk("t1_valid1", 32'(valid),  1);
        chk("t1_nodone", 32'(done),   0);
        stop = 2'b10; stop_fine[13:7] = 7'b0011111;
        step(1);                            // E6
        stop = '0;
        chk("t1_res1",   32'(res(1)), 46);
        chk("t1_valid2", 32'(valid),  3);
        chk("t1_done",   32'(done),   1);
        chk("t1_busy0",  32'(busy),   0);
        step(1);
        chk("t1_done1cyc", 32'(done), 0);
        chk("t1_idle",     32'(busy), 0);
        chk("t1_hold0",    32'(res(0)), 42);

        // 2: overflow, stop[0] at E15 -> 15*8+0-0=120, ch1 times out
        start = 1'b1; start_fine = '0; stop_fine = '0;
        step(1);                            // E0
        start = 1'b0;
        chk("t2_cleared", 32'(valid), 0);
        step(14);                           // E1..E14
        stop = 2'b01;
        step(1);                            // E15
        stop = '0;
        chk("t2_res0",  32'(res(0)), 120);
        chk("t2_res1",  32'(res(1)), 127);
        chk("t2_valid", 32'(valid),  1);
        chk("t2_ovf",   32'(ovf),    2);
        chk("t2_done",  32'(done),   1);
        step(1);
        chk("t2_done1cyc", 32'(done), 0);
        chk("t2_hold_ovf", 32'(ovf),  2);

        // 3: edge cases
        start = 1'b1; stop = 2'b01; start_fine = '0; stop_fine = '0;
        step(1);                            // E0: stop ignored
        start = 1'b0; stop = '0;
        chk("t3_ovf_clr", 32'(ovf), 0);
        chk("t3_same_edge", 32'(valid), 0);
        step(1);                            // E1
        stop = 2'b01;
        step(1);                            // E2 -> 16
        stop = '0;
        chk("t3_res0", 32'(res(0)), 16);
        chk("t3_val0", 32'(valid), 1);
        start = 1'b1;
        step(1);                            // E3: start ignored
        start = 1'b0;
        chk("t3_busy", 32'(busy), 1);
        stop = 2'b01; stop_fine[6:0] = 7'b1111111;
        step(1);                            // E4: repeat stop ignored
        stop = '0; stop_fine = '0;
        chk("t3_repeat", 32'(res(0)), 16);
        step(1);                            // E5
        stop = 2'b10;
        step(1);                            // E6 -> 48 if cnt untouched
        stop = '0;
        chk("t3_res1", 32'(res(1)), 48);
        chk("t3_done", 32'(done), 1);
        step(1);

        // 4: bubble start code, popcount 3 -> 8+3-0=11 on both
        start = 1'b1; start_fine = 7'b0001011;
        step(1);                            // E0
        start = 1'b0;
        stop = 2'b11;
        step(1);                            // E1
        stop = '0;
        chk("t4_res0", 32'(res(0)), 11);
        chk("t4_res1", 32'(res(1)), 11);
        chk("t4_done", 32'(done), 1);
        step(1);
        stop = 2'b11; stop_fine = {7'b1111111, 7'b1111111};
        step(1);                            // stop in IDLE ignored
        stop = '0; stop_fine = '0;
        chk("t4_idle_stop", 32'(res(0)), 11);
        chk("t4_idle_busy", 32'(busy), 0);

        // 5: reset mid-run, then a normal run: 2*8+3-0=19
        start = 1'b1; start_fine = 7'b0000111;
        step(1);                            // E0
        start = 1'b0;
        stop = 2'b01;
        step(1);                            // E1 -> ch0 captures 11
        stop = '0;
        chk("t5_pre_rst", 32'(res(0)), 11);
        step(1);                            // E2
        reset = 1'b0;
        step(1);                            // E3
        reset = 1'b1;
        chk("t5_result", 32'(result), 0);
        chk("t5_valid",  32'(valid),  0);
        chk("t5_busy",   32'(busy),   0);
        chk("t5_done",   32'(done),   0);
        step(1);
        chk("t5_no_done", 32'(done), 0);
        start = 1'b1;
        step(1);                            // E0'
        start = 1'b0;
        step(1);                            // E1'
        stop = 2'b11;
        step(1);                            // E2'
        stop = '0;
        chk("t5_res0", 32'(res(0)), 19);
        chk("t5_res1", 32'(res(1)), 19);
        chk("t5_done2", 32'(done), 1);
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vernier_tdc_mc.md
Name: vernier_tdc_mc

Overview:
Parametrised multi-channel Vernier time-to-digital converter. It is the next generation of the 6-bit Vernier TDC.
- One shared start event and CHANNELS independent stop events.
- Each interval is measured as a coarse clock-cycle count plus a fine correction. The fine correction comes from external delay-line thermometer codes captured at the start and stop edges.
- Adds configurable resolution, per-channel overflow detection, a busy/done handshake and held results. It sits between the delay-line samplers and the readout logic.

Parameters:
CHANNELS, 4, number of stop channels (1..16)
COARSE_BITS, 6, coarse counter width; max coarse count 2^COARSE_BITS-1
FINE_BITS, 3, fine binary width; thermometer width TAPS = 2^FINE_BITS-1

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  start event pulse, synchronous to clk
start_fine  in  TAPS  start thermometer code, sampled with start
stop  in  CHANNELS  per-channel stop event pulses
stop_fine  in  CHANNELS*TAPS  per-channel stop thermometer codes; channel i at [i*TAPS +: TAPS]
result  out  CHANNELS*(COARSE_BITS+FINE_BITS)  per-channel interval; channel i at [i*W +: W], W=COARSE_BITS+FINE_BITS
valid  out  CHANNELS  channel result captured
ovf  out  CHANNELS  channel timed out without a stop
busy  out  1  measurement in progress
done  out  1  one-cycle pulse when a measurement completes

Behaviour:
- Reset: reset=0 at a clk edge clears all state. FSM goes to IDLE; result, valid, ovf, busy, done and the coarse counter all become 0. A reset mid-measurement aborts it with no done pulse.
- FSM states and transitions:
  - IDLE: start=1 at edge E0 → RUN. At E0: cnt<=1; start_bin <= popcount(start_fine); result, valid and ovf cleared. busy=1 from after E0. stop in IDLE is ignored.
  - RUN: at each edge, each channel i with stop[i]=1 and valid[i]=0 captures:
    - result[i] <= cnt*2^FINE_BITS + start_bin − popcount(stop_fine[i]);
    - valid[i] <= 1.
    - Then cnt<=cnt+1.
    - If all channels are valid after this edge → DONE.
    - Else, if cnt == 2^COARSE_BITS−1 at this edge → every still-invalid channel gets ovf[i]<=1 and result[i]<=all-ones, then → DONE.
    - start in RUN is ignored.
  - DONE: lasts exactly one cycle; done=1, busy=0; then → IDLE. start in DONE is ignored.
- Coarse count semantics: a stop sampled at edge Em (m≥1 edges after E0) gives coarse = m. A stop on the same edge as start (E0) is ignored. That channel remains eligible for later stops.
- Fine code: binary value = number of ones in the thermometer code (popcount), so bubble errors are tolerated. The fine code represents the time from the event to the sampling edge.
- Result range:
  - The minimum valid result is 1 (m=1, start_bin=0, stop_bin=TAPS), so the result never underflows.
  - The maximum is 2^W−1. An all-ones value is disambiguated by ovf.
- Repeated stop on an already-valid channel: ignored. Simultaneous stops on several channels: all captured on the same edge.
- Latency: result and valid are visible in the cycle after the capturing edge. done follows the completing edge by one cycle.
- Holding: results, valid and ovf hold through DONE and IDLE until the next accepted start or reset.

Test Plan:
1. CHANNELS=2, COARSE_BITS=4, FINE_BITS=3 for all scenarios.
   - Stimulus: start at E0 with start_fine=0000111; stop[0] at E5 with fine=0000001; stop[1] at E6 with fine=0011111.
   - Required: result0=42 and valid0=1 after E5; result1=46 after E6; done=1 for one cycle, then busy=0.
2. Overflow: start at E0; stop[0] at E15 only.
   - Required: at E15 result0 captured and valid0=1; ovf1=1, result1=127, valid1=0; done pulses.
3. Edge cases:
   - stop[0] on the same edge as start → ignored.
   - stop[0] again at E2 → captured with coarse=2.
   - stop[0] again at E4 → ignored; result0 unchanged.
   - start pulses during RUN → no restart, cnt unaffected.
4. Bubble code: start_fine=0001011 (popcount 3) at E0; stop both channels at E1 with fine=0000000.
   - Required: result0=result1=11 after E1; done in the following cycle.
5. Reset mid-run: reset=0 at E3.
   - Required: all outputs 0 after E3, no done pulse.
   - Then start at E0', stop both channels at E2' (fine 0) → result=16+start_bin, measured normally.
